mar_mdr_mem_if: RTL and testbench

Memory interface stage downstream of the program counter on the shared CPU bus: latches addresses (from PC or ALU) into the Memory Address Register (MAR) and data into the Memory Data Register (MDR), and runs a request/acknowledge handshake to instruction/data memory. It is the only block that talks to memory. Its MDR drives fetched words back onto the tri-state bus for the instruction register and general registers.

---
 rtl/mar_mdr_mem_if_if.sv | 42 ++++
 rtl/mar_mdr_mem_if.sv | 170 +++++++++++++++++
 tb/tb_mar_mdr_mem_if.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mar_mdr_mem_if_if.sv
// -----------------------------------------------------------------------------
// mar_mdr_mem_if_if
// Memory-side handshake bundle between the MAR/MDR stage and instruction/data
// memory.
//
//   mem_addr   memory address (MAR)             stage -> memory
//   mem_wdata  memory write data (MDR)          stage -> memory
//   mem_req    request, held until ack/timeout  stage -> memory
//   mem_we     1 = write, 0 = read              stage -> memory
//   mem_rdata  read data, valid with mem_ack    memory -> stage
//   mem_ack    one-cycle acknowledge            memory -> stage
//
// The master modport belongs to the MAR/MDR stage, the slave modport to memory.
// -----------------------------------------------------------------------------
interface mar_mdr_mem_if_if #(
    parameter int W = 32
) ();
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_rdata;
    logic         mem_ack;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_req,
        output mem_we,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_req,
        input  mem_we,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mar_mdr_mem_if.sv
// -----------------------------------------------------------------------------
// mar_mdr_mem_if
// Memory interface stage on the shared CPU bus. Latches an address into the
// MAR and data into the MDR from the tri-state bus, runs a req/ack handshake
// with memory, and drives the MDR back onto the bus on request.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous reset, active low
//   io_bus     shared tri-state CPU bus (driven only while i_mdr_out)
//   i_mar_in   load MAR from bus (IDLE only)
//   i_mdr_in   load MDR from bus (IDLE only)
//   i_mdr_out  drive MDR onto bus (any state)
//   i_read     start read at MAR
//   i_write    start write of MDR to MAR (wins over i_read)
//   o_busy     transaction in progress
//   o_done     one-cycle pulse when a transaction ends
//   o_err      one-cycle pulse with o_done when the transaction timed out
//   mem        memory handshake bundle (master side)
//
// State table
//   state   | meaning
//   IDLE    | accepts register loads and Read/Write; mem_req low
//   BUSY    | mem_req high, waiting up to TMO cycles for mem_ack
// -----------------------------------------------------------------------------
module mar_mdr_mem_if #(
    parameter int W   = 32,
    parameter int TMO = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    inout  wire  [W-1:0]      io_bus,
    input  logic              i_mar_in,
    input  logic              i_mdr_in,
    input  logic              i_mdr_out,
    input  logic              i_read,
    input  logic              i_write,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    mar_mdr_mem_if_if.master  mem
);

    localparam int            CW       = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [W-1:0]  r_mar;
    logic [W-1:0]  r_mdr;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic          r_done;
    logic          r_err;

    logic [W-1:0]  w_bus_in;
    logic          w_start;
    logic          w_start_we;
    logic          w_finish;
    logic          w_timeout;

    // The bus is only ever driven from the MDR.
    assign io_bus   = i_mdr_out ? r_mdr : {W{1'bz}};
    assign w_bus_in = io_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_we  = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_write) begin
                    w_start     = 1'b1;
                    w_start_we  = 1'b1;
                    w_state_nxt = ST_BUSY;
                end else if (i_read) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // An ack on the last permitted cycle still completes normally.
                if (mem.mem_ack) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mar <= '0;
        end else if (r_state == ST_IDLE && i_mar_in) begin
            r_mar <= w_bus_in;
        end
    end

    // With MDRout and MDRin together the bus carries the MDR itself, so the
    // load is suppressed rather than relying on reading back our own drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdr <= '0;
        end else if (r_state == ST_IDLE) begin
            if (i_mdr_in && !i_mdr_out) begin
                r_mdr <= w_bus_in;
            end
        end else if (mem.mem_ack && !r_we) begin
            r_mdr <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (r_state == ST_BUSY && !w_finish) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_err  <= w_timeout;
            if (w_start) begin
                r_we <= w_start_we;
            end else if (w_finish) begin
                r_we <= 1'b0;
            end
        end
    end

    assign o_busy        = (r_state == ST_BUSY);
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign mem.mem_req   = (r_state == ST_BUSY);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_mar;
    assign mem.mem_wdata = r_mdr;

endmodule

// File: tb/tb_mar_mdr_mem_if.sv
module tb_mar_mdr_mem_if;
    localparam int W   = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wire  [W-1:0] bus;
    logic [W-1:0] tb_bus_val = '0;
    logic         tb_bus_en  = 1'b0;
    assign bus = tb_bus_en ? tb_bus_val : {W{1'bz}};

    logic i_mar_in = 0, i_mdr_in = 0, i_mdr_out = 0, i_read = 0, i_write = 0;
    logic o_busy, o_done, o_err;

    mar_mdr_mem_if_if #(.W(W)) mif ();

    mar_mdr_mem_if #(.W(W), .TMO(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io_bus    (bus),
        .i_mar_in  (i_mar_in),
        .i_mdr_in  (i_mdr_in),
        .i_mdr_out (i_mdr_out),
        .i_read    (i_read),
        .i_write   (i_write),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .mem       (mif)
    );

    typedef struct {
        logic         err;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic         we;
        int           lat;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int pushed = 0;
    int dones = 0;

    // Reference state: what MAR and MDR hold according to the bus rules.
    logic [W-1:0] m_mar = '0;
    logic [W-1:0] m_mdr = '0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation for every done pulse.
    int   req_cnt = 0;
    logic last_we = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            req_cnt   = 0;
            prev_done = 1'b0;
        end else begin
            if (mif.mem_req) begin
                req_cnt++;
                last_we = mif.mem_we;
            end
            if (o_err && !o_done) chk("err_without_done", 32'(o_err), 32'(0));
            if (prev_done && o_done) chk("done_width", 32'(o_done), 32'(0));
            if (o_done) begin
                dones++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(o_done), 32'(0));
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("err", 32'(o_err), 32'(e.err));
                    chk("mem_addr", mif.mem_addr, e.addr);
                    chk("mdr_after", mif.mem_wdata, e.wdata);
                    chk("mem_we", 32'(last_we), 32'(e.we));
                    chk("req_cycles", 32'(req_cnt), 32'(e.lat));
                    chk("mem_req_at_done", 32'(mif.mem_req), 32'(0));
                end
                req_cnt = 0;
            end
            prev_done = o_done;
        end
    end

    task automatic clear_inputs();
        i_mar_in = 0; i_mdr_in = 0; i_mdr_out = 0; i_read = 0; i_write = 0;
        tb_bus_en = 0;
        mif.mem_ack = 0;
    endtask

    task automatic load(input bit to_mdr, input logic [W-1:0] val);
        @(posedge clk); #1;
        tb_bus_en = 1; tb_bus_val = val;
        if (to_mdr) i_mdr_in = 1; else i_mar_in = 1;
        @(posedge clk); #1;
        clear_inputs();
        if (to_mdr) begin
            m_mdr = val;
            chk("load_mdr", mif.mem_wdata, m_mdr);
        end else begin
            m_mar = val;
            chk("load_mar", mif.mem_addr, m_mar);
        end
    endtask

    // Drives MDRout (with MDRin set as well, which must not disturb MDR).
    task automatic read_bus();
        @(posedge clk); #1;
        i_mdr_out = 1; i_mdr_in = 1;
        #1 chk("bus_mdr", bus, m_mdr);
        @(posedge clk); #1;
        chk("bus_mdr_held", bus, m_mdr);
        clear_inputs();
    endtask

    // d = edge offset after the command edge at which ack is sampled; 0 = never.
    task automatic txn(input bit rd, input bit wr, input bit ld_mar, input logic [W-1:0] ld_val,
                       input int d, input logic [W-1:0] rdata, input bit stray);
        exp_t e;
        int   n;
        bit   tmo;
        @(posedge clk); #1;
        i_read = rd; i_write = wr;
        if (ld_mar) begin
            i_mar_in = 1; tb_bus_en = 1; tb_bus_val = ld_val;
            m_mar = ld_val;
        end
        tmo = (d == 0);
        if (!tmo && !wr) m_mdr = rdata;
        e.err = tmo; e.addr = m_mar; e.wdata = m_mdr; e.we = wr;
        e.lat = tmo ? TMO : d;
        q.push_back(e);
        pushed++;
        n = e.lat;
        @(posedge clk); #1;
        clear_inputs();
        for (int k = 1; k <= n; k++) begin
            mif.mem_rdata = $urandom;
            if (k == n && !tmo) begin
                mif.mem_ack = 1; mif.mem_rdata = rdata;
            end else if (stray) begin
                i_mar_in = 1'($urandom); i_mdr_in = 1'($urandom);
                i_read = 1'($urandom); i_write = 1'($urandom);
                tb_bus_en = 1; tb_bus_val = $urandom;
            end
            @(posedge clk); #1;
            clear_inputs();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        mif.mem_rdata = '0;
        #23;
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_req", 32'(mif.mem_req), 0);
        chk("rst_we", 32'(mif.mem_we), 0);
        chk("rst_done", 32'(o_done), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_mar", mif.mem_addr, 0);
        chk("rst_mdr", mif.mem_wdata, 0);
        rst_n = 1;

        read_bus();
        // Directed read
        load(0, 32'h0000_000F);
        txn(1, 0, 0, 0, 2, 32'hDEAD_BEEF, 0);
        read_bus();
        // Directed write, ack at first opportunity
        load(0, 32'h0000_0040);
        load(1, 32'h1234_5678);
        txn(0, 1, 0, 0, 1, 32'h0BAD_0BAD, 0);
        // Timeout with stray inputs during BUSY, then a normal read
        txn(1, 0, 0, 0, 0, 32'h0, 1);
        chk("mar_after_stray", mif.mem_addr, 32'h0000_0040);
        txn(1, 0, 0, 0, 1, 32'hCAFE_F00D, 0);
        // Ack on the last permitted cycle completes without error
        txn(1, 0, 0, 0, TMO, 32'h5555_AAAA, 1);
        // Read and Write together: write wins
        txn(1, 1, 0, 0, 3, 32'hFFFF_FFFF, 0);
        // Ack while IDLE is ignored
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            mif.mem_ack = 1; mif.mem_rdata = $urandom;
            @(posedge clk); #1;
            mif.mem_ack = 0;
        end
        read_bus();
        // MARin in the same cycle as the command
        txn(1, 0, 1, 32'h0000_0123, 2, 32'h7777_0001, 0);

        for (int i = 0; i < 60; i++) begin
            int op;
            if ($urandom_range(0, 3) == 0) load(0, $urandom);
            if ($urandom_range(0, 3) == 0) load(1, $urandom);
            op = $urandom_range(0, 2);
            txn(op != 1, op != 0, 1'($urandom_range(0, 3) == 0), $urandom,
                $urandom_range(0, TMO), $urandom, 1'($urandom));
            if ($urandom_range(0, 4) == 0) read_bus();
        end

        // Reset in the middle of a transaction
        load(0, 32'h0000_0AAA);
        load(1, 32'h0000_0BBB);
        @(posedge clk); #1;
        i_read = 1;
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("mid_rst_busy", 32'(o_busy), 0);
        chk("mid_rst_req", 32'(mif.mem_req), 0);
        chk("mid_rst_done", 32'(o_done), 0);
        chk("mid_rst_mar", mif.mem_addr, 0);
        chk("mid_rst_mdr", mif.mem_wdata, 0);
        m_mar = '0; m_mdr = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        read_bus();
        txn(0, 1, 1, 32'h0000_0040, 2, 32'h0, 0);

        repeat (4) @(posedge clk);
        chk("pending_expectations", 32'(q.size()), 0);
        chk("done_count", 32'(dones), 32'(pushed));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
